// File: rtl/visited_set_tracker.sv
// Bit-packed visited table with running unique count; one lookup per accepted (x,y), result 2 cycles after accept.
// in_ready low while sweeping, after in_last, or once a clear is pending; no internal stalls while in RUN.
module visited_set_tracker #(
    parameter int POSITION_WIDTH = 8,
    parameter int WORD_SEL_BITS  = 3,
    parameter int COUNT_WIDTH    = 17
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [POSITION_WIDTH-1:0] in_x,
    input  logic [POSITION_WIDTH-1:0] in_y,
    input  logic                      in_last,
    input  logic                      clear_req,
    output logic                      busy,
    output logic                      lookup_valid,
    output logic                      lookup_already_visited,
    output logic [COUNT_WIDTH-1:0]    unique_count,
    output logic                      done
);
    localparam int FLAT_W = 2 * POSITION_WIDTH;
    localparam int ADDR_W = FLAT_W - WORD_SEL_BITS;
    localparam int WORD_W = 1 << WORD_SEL_BITS;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic                clr_pend_q, clr_pend_d;
    logic                restart;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   rd_word_q;

    logic                s1_vld_q, s1_last_q;
    logic [ADDR_W-1:0]   s1_addr_q;
    logic [WORD_SEL_BITS-1:0] s1_sel_q;

    logic                fwd_vld_q;
    logic [ADDR_W-1:0]   fwd_addr_q;
    logic [WORD_W-1:0]   fwd_word_q;

    logic                lv_q, already_q, done_q;
    logic [COUNT_WIDTH-1:0] count_q;

    logic [FLAT_W-1:0]   flat;
    logic [ADDR_W-1:0]   in_addr;
    logic [WORD_SEL_BITS-1:0] in_sel;
    logic                accept;
    logic                pipe_empty;
    logic [WORD_W-1:0]   base_word, sel_mask, merged_word;
    logic                s1_hit;

    assign flat     = {in_x, in_y};
    assign in_addr  = flat[FLAT_W-1:WORD_SEL_BITS];
    assign in_sel   = flat[WORD_SEL_BITS-1:0];
    assign in_ready = (state_q == ST_RUN) && !clr_pend_q;
    assign busy     = (state_q == ST_CLEAR);
    assign accept   = in_valid && in_ready;
    assign pipe_empty = !accept && !s1_vld_q && !lv_q;

    // RAM read for this beat raced the previous beat's write; take the written word instead.
    always_comb begin
        base_word   = (fwd_vld_q && (fwd_addr_q == s1_addr_q)) ? fwd_word_q : rd_word_q;
        sel_mask    = WORD_W'(1) << s1_sel_q;
        merged_word = base_word | sel_mask;
        s1_hit      = |(base_word & sel_mask);
    end

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        clr_pend_d = clr_pend_q;
        restart    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_pend_d = 1'b0;
                sweep_d    = sweep_q + 1'b1;
                if (sweep_q == '1) state_d = ST_RUN;
            end
            ST_RUN, ST_DONE: begin
                if (state_q == ST_RUN && accept && in_last) state_d = ST_DONE;
                if (clear_req || clr_pend_q) begin
                    clr_pend_d = 1'b1;
                    if (pipe_empty) begin
                        state_d    = ST_CLEAR;
                        sweep_d    = '0;
                        clr_pend_d = 1'b0;
                        restart    = 1'b1;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            sweep_q    <= '0;
            clr_pend_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            fwd_vld_q  <= 1'b0;
            lv_q       <= 1'b0;
            already_q  <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            clr_pend_q <= clr_pend_d;
            s1_vld_q   <= accept;
            fwd_vld_q  <= s1_vld_q;
            lv_q       <= s1_vld_q;
            already_q  <= s1_vld_q && s1_hit;
            if (restart) begin
                done_q  <= 1'b0;
                count_q <= '0;
            end else begin
                if (s1_vld_q && s1_last_q) done_q <= 1'b1;
                if (lv_q && !already_q && (count_q != '1)) count_q <= count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        rd_word_q <= mem[in_addr];
        if (accept) begin
            s1_addr_q <= in_addr;
            s1_sel_q  <= in_sel;
            s1_last_q <= in_last;
        end
        fwd_addr_q <= s1_addr_q;
        fwd_word_q <= merged_word;
        if (state_q == ST_CLEAR) mem[sweep_q] <= '0;
        else if (s1_vld_q) mem[s1_addr_q] <= merged_word;
    end

    assign lookup_valid           = lv_q;
    assign lookup_already_visited = already_q;
    assign unique_count           = count_q;
    assign done                   = done_q;
endmodule

// File: tb/tb_visited_set_tracker.sv
// Directed bench: 3-bit coordinates, 4 flags/word (16-word RAM); a second instance with a 3-bit count checks saturation.
module tb_visited_set_tracker;
    logic       clk = 1'b0;
    logic       reset, in_valid, in_last, clear_req;
    logic [2:0] in_x, in_y;
    logic       in_ready, busy, lookup_valid, lookup_already_visited, done;
    logic [16:0] unique_count;
    logic       s_in_ready, s_busy, s_lookup_valid, s_lookup_already_visited, s_done;
    logic [2:0] s_unique_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] x;
        logic [2:0] y;
        logic       last;
        logic       exp;
    } vec_t;
    vec_t vt [10];

    always #5 clk = ~clk;

    visited_set_tracker #(.POSITION_WIDTH(3), .WORD_SEL_BITS(2), .COUNT_WIDTH(17)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_last(in_last), .clear_req(clear_req),
        .busy(busy), .lookup_valid(lookup_valid),
        .lookup_already_visited(lookup_already_visited),
        .unique_count(unique_count), .done(done)
    );

    visited_set_tracker #(.POSITION_WIDTH(3), .WORD_SEL_BITS(2), .COUNT_WIDTH(3)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_x(in_x), .in_y(in_y), .in_last(in_last), .clear_req(clear_req),
        .busy(s_busy), .lookup_valid(s_lookup_valid),
        .lookup_already_visited(s_lookup_already_visited),
        .unique_count(s_unique_count), .done(s_done)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts busy cycles from the current sample; flags any lookup strobe seen during the sweep.
    task automatic wait_sweep(input string name);
        int n = 0;
        logic lv_seen = 1'b0;
        while (busy && n < 100) begin
            if (lookup_valid) lv_seen = 1'b1;
            n++;
            step();
        end
        chk({name, "_busy_cycles"}, n, 16);
        chk({name, "_no_lv_in_sweep"}, lv_seen, 0);
        chk({name, "_ready"}, in_ready, 1);
        chk({name, "_count"}, unique_count, 0);
        chk({name, "_done"}, done, 0);
    endtask

    task automatic do_clear(input string name);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk({name, "_count_zero"}, unique_count, 0);
        wait_sweep(name);
    endtask

    task automatic run_burst(input int first, input int n);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                in_valid = 1'b1;
                in_x     = vt[first+i].x;
                in_y     = vt[first+i].y;
                in_last  = vt[first+i].last;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            step();
            if (i == 0) begin
                chk("lv_not_before_2_cycles", lookup_valid, 0);
            end else begin
                chk("lv", lookup_valid, 1);
                chk("already", lookup_already_visited, vt[first+i-1].exp);
                chk("done_with_result", done, vt[first+i-1].last);
            end
            if (i < n && vt[first+i].last) chk("ready_after_last", in_ready, 0);
        end
        step();
    endtask

    task automatic single_beat(input logic [2:0] x, input logic [2:0] y, input logic exp);
        in_valid = 1'b1; in_x = x; in_y = y; in_last = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        chk("single_lv", lookup_valid, 1);
        chk("single_already", lookup_already_visited, exp);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [5:0] f;
        vt[0] = '{3'd0, 3'd0, 1'b0, 1'b0};
        vt[1] = '{3'd0, 3'd1, 1'b0, 1'b0};
        vt[2] = '{3'd0, 3'd0, 1'b0, 1'b1};
        vt[3] = '{3'd1, 3'd0, 1'b0, 1'b0};
        vt[4] = '{3'd0, 3'd0, 1'b0, 1'b0};
        vt[5] = '{3'd0, 3'd1, 1'b0, 1'b0};
        vt[6] = '{3'd0, 3'd2, 1'b0, 1'b0};
        vt[7] = '{3'd0, 3'd3, 1'b0, 1'b0};
        vt[8] = '{3'd0, 3'd1, 1'b1, 1'b1};
        vt[9] = '{3'd0, 3'd1, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; clear_req = 1'b0;
        in_x = '0; in_y = '0;
        step();
        reset = 1'b0;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_lv", lookup_valid, 0);
        chk("rst_already", lookup_already_visited, 0);
        chk("rst_count", unique_count, 0);
        chk("rst_done", done, 0);
        wait_sweep("reset");

        // back-to-back with a same-word revisit
        run_burst(0, 4);
        chk("t2_count", unique_count, 3);
        do_clear("t2_clear");

        // same-word burst; final beat carries in_last
        run_burst(4, 5);
        chk("t4_count", unique_count, 4);
        chk("t4_done_sticky", done, 1);
        chk("t4_ready_low", in_ready, 0);
        do_clear("t4_clear");
        run_burst(9, 1);
        chk("t4_replay_count", unique_count, 1);

        // saturation on the narrow instance
        do_clear("t5_clear");
        chk("t5_sat_count_start", s_unique_count, 0);
        for (int k = 1; k <= 9; k++) begin
            f = 6'(k * 5);
            in_valid = 1'b1; in_x = f[5:3]; in_y = f[2:0]; in_last = 1'b0;
            step();
            in_valid = 1'b0;
            step();
            chk("t5_sat_lv", s_lookup_valid, 1);
            chk("t5_sat_already", s_lookup_already_visited, 0);
            step();
            chk("t5_count_wide", unique_count, k);
            chk("t5_count_sat", s_unique_count, (k > 7) ? 7 : k);
        end

        // reset with beats in flight
        in_valid = 1'b1; in_x = 3'd7; in_y = 3'd7; in_last = 1'b0;
        step();
        in_x = 3'd7; in_y = 3'd6;
        step();
        chk("t6_first_result", lookup_valid, 1);
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_lv_after_reset", lookup_valid, 0);
        chk("t6_count_after_reset", unique_count, 0);
        chk("t6_busy_after_reset", busy, 1);
        wait_sweep("t6");
        chk("t6_no_late_lv", lookup_valid, 0);
        single_beat(3'd7, 3'd7, 1'b0);
        chk("t6_count_one", unique_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
